// File: rtl/apb_slave_regfile_pkg.sv
// rtl/apb_slave_regfile_pkg.sv - shared constants and types for the APB register-file slave
package apb_slave_pkg;

    localparam int NUM_REGS = 8;
    localparam int NUM_RW   = 6;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_RESP_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_RESP = ST_RESP_ENC
    } state_t;

    localparam logic [2:0] OFF_CTRL   = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd6;
    localparam logic [2:0] OFF_ID     = 3'd7;

    // Read data returned alongside Pslverr.
    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    function automatic logic is_read_only(input logic [2:0] off);
        return (off == OFF_STATUS) || (off == OFF_ID);
    endfunction

endpackage

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - six read/write words plus status and ID read-only words
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_idx,
    input  logic [31:0] wr_data,
    input  logic [2:0]  rd_idx,
    output logic [31:0] rd_data,
    input  logic [31:0] status_in,
    output logic [31:0] ctrl
);

    logic [31:0] rw_q [NUM_RW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_en && (wr_idx == 3'(i))) begin
                    rw_q[i] <= wr_data;
                end
            end
        end
    end

    // The status word is read live: its consumer is the response register, so the
    // value returned is exactly the one sampled at the edge that enters RESP.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rd_idx == 3'(i)) begin
                rd_data = rw_q[i];
            end
        end
        if (rd_idx == OFF_STATUS) begin
            rd_data = status_in;
        end
        if (rd_idx == OFF_ID) begin
            rd_data = ID_VALUE;
        end
    end

    assign ctrl = rw_q[0];

endmodule

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer with wait states, address decode and error response
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int          SEL_IDX     = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    input  logic [31:0] Status_in,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic [31:0] Ctrl_out
);

    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES - 1);

    logic        sel;
    logic        setup;
    logic        access;
    logic        hit;
    logic [2:0]  off_in;
    logic        err_in;

    assign sel    = |(Pselx & (3'b001 << SEL_IDX));
    assign setup  = sel & ~Penable;
    assign access = sel & Penable;
    assign off_in = Paddr[4:2];
    assign hit    = (Paddr[31:5] == BASE_ADDR[31:5]) && (Paddr[1:0] == 2'b00);
    assign err_in = !hit || (Pwrite && is_read_only(off_in));

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  off_q;
    logic        write_q;
    logic        err_q;
    logic        latch;
    logic        enter_resp;
    logic        wr_en;
    logic        resp_err;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;

    // With zero wait states RESP is entered straight from the setup cycle, before
    // the decode has been latched, so the live decode feeds the response.
    assign rd_idx   = (state_q == ST_IDLE) ? off_in : off_q;
    assign resp_err = (state_q == ST_IDLE) ? err_in : err_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        enter_resp = 1'b0;
        wr_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (setup) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (access) begin
                    if (cnt_q == 3'd0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                wr_en   = access & write_q & ~err_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hreset) begin
        if (!Hreset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            Pready  <= 1'b0;
            Pslverr <= 1'b0;
            Prdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch) begin
                off_q   <= off_in;
                write_q <= Pwrite;
                err_q   <= err_in;
            end
            Pready  <= enter_resp;
            Pslverr <= enter_resp & resp_err;
            Prdata  <= (enter_resp && !resp_err) ? rd_data :
                       (enter_resp ? ERR_RDATA : 32'h0);
        end
    end

    apb_slave_regbank #(
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk       (Hclk),
        .rst_n     (Hreset),
        .wr_en     (wr_en),
        .wr_idx    (off_q),
        .wr_data   (Pwdata),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .status_in (Status_in),
        .ctrl      (Ctrl_out)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed table-driven bench for apb_slave_regfile
module tb_apb_slave_regfile;

    logic        Hclk = 1'b0;
    logic        Hreset = 1'b0;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Status_in;

    logic [31:0] prdata1, prdata0, prdata3;
    logic        pready1, pready0, pready3;
    logic        pslverr1, pslverr0, pslverr3;
    logic [31:0] ctrl1, ctrl0, ctrl3;

    logic [31:0] mon_prdata;
    logic        mon_pready;
    logic        mon_pslverr;
    logic [31:0] mon_ctrl;
    int          cur;

    int total = 0;
    int bad   = 0;

    always #5 Hclk = ~Hclk;

    apb_slave_regfile #(.SEL_IDX(0), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(1), .ID_VALUE(32'hA5B0_0001)) u_ws1 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Status_in(Status_in),
        .Prdata(prdata1), .Pready(pready1), .Pslverr(pslverr1), .Ctrl_out(ctrl1));

    apb_slave_regfile #(.SEL_IDX(0), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)) u_ws0 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Status_in(Status_in),
        .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0), .Ctrl_out(ctrl0));

    apb_slave_regfile #(.SEL_IDX(0), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(3), .ID_VALUE(32'hA5B0_0001)) u_ws3 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Status_in(Status_in),
        .Prdata(prdata3), .Pready(pready3), .Pslverr(pslverr3), .Ctrl_out(ctrl3));

    always_comb begin
        mon_prdata  = prdata1;
        mon_pready  = pready1;
        mon_pslverr = pslverr1;
        mon_ctrl    = ctrl1;
        if (cur == 0) begin
            mon_prdata = prdata0; mon_pready = pready0; mon_pslverr = pslverr0; mon_ctrl = ctrl0;
        end else if (cur == 3) begin
            mon_prdata = prdata3; mon_pready = pready3; mon_pslverr = pslverr3; mon_ctrl = ctrl3;
        end
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        Hreset  = 1'b0;
        Pselx   = 3'b000;
        Penable = 1'b0;
        repeat (2) @(posedge Hclk);
        #1;
        Hreset = 1'b1;
    endtask

    // Setup + access phases; returns the access cycle in which Pready was seen (-1 on timeout).
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output logic [31:0] ctrl_resp);
        int  n;
        logic got;
        Pselx = 3'b001; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = data;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        n = 0; got = 1'b0; rdata = '0; err = 1'b0; ctrl_resp = '0;
        while (!got && n < 20) begin
            n++;
            @(negedge Hclk);
            if (mon_pready) begin
                got = 1'b1; rdata = mon_prdata; err = mon_pslverr; ctrl_resp = mon_ctrl;
            end
            @(posedge Hclk); #1;
        end
        Pselx = 3'b000; Penable = 1'b0;
        lat = got ? n : -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        v [16];
        logic [31:0] rd, cr;
        logic        er, seen;
        int          lat;

        v[0]  = '{1'b0, 32'h8000_001C, 32'h0,          32'hA5B0_0001, 1'b0, "rd_id"};
        v[1]  = '{1'b1, 32'h8000_0004, 32'h1111_1111, 32'h0,          1'b0, "wr_r1"};
        v[2]  = '{1'b1, 32'h8000_000C, 32'h3333_3333, 32'h0,          1'b0, "wr_r3"};
        v[3]  = '{1'b1, 32'h8000_0014, 32'h5555_5555, 32'h0,          1'b0, "wr_r5"};
        v[4]  = '{1'b1, 32'h8000_001C, 32'h1234_5678, 32'h0,          1'b1, "wr_id_err"};
        v[5]  = '{1'b1, 32'h9000_0004, 32'h9999_9999, 32'h0,          1'b1, "wr_miss_err"};
        v[6]  = '{1'b1, 32'h8000_0002, 32'h2222_2222, 32'h0,          1'b1, "wr_misal_err"};
        v[7]  = '{1'b1, 32'h8000_0018, 32'h6666_6666, 32'h0,          1'b1, "wr_stat_err"};
        v[8]  = '{1'b0, 32'h8000_0000, 32'h0,          32'hDEAD_BEEF, 1'b0, "rd_r0"};
        v[9]  = '{1'b0, 32'h8000_0004, 32'h0,          32'h1111_1111, 1'b0, "rd_r1"};
        v[10] = '{1'b0, 32'h8000_000C, 32'h0,          32'h3333_3333, 1'b0, "rd_r3"};
        v[11] = '{1'b0, 32'h8000_0014, 32'h0,          32'h5555_5555, 1'b0, "rd_r5"};
        v[12] = '{1'b0, 32'h8000_0018, 32'h0,          32'hCAFE_0006, 1'b0, "rd_status"};
        v[13] = '{1'b0, 32'h8000_0008, 32'h0,          32'h0000_0000, 1'b0, "rd_r2"};
        v[14] = '{1'b0, 32'h9000_0000, 32'h0,          32'h0000_0000, 1'b1, "rd_miss_err"};
        v[15] = '{1'b0, 32'h8000_0005, 32'h0,          32'h0000_0000, 1'b1, "rd_misal_err"};

        Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = '0; Pwdata = '0;
        Status_in = 32'hCAFE_0006;
        cur = 1;
        do_reset();

        chk("rst_pready",  {31'b0, mon_pready},  32'h0);
        chk("rst_pslverr", {31'b0, mon_pslverr}, 32'h0);
        chk("rst_prdata",  mon_prdata, 32'h0);
        chk("rst_ctrl",    mon_ctrl,   32'h0);

        xfer(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, rd, er, lat, cr);
        chk("ctrl_wr_lat",      32'(lat), 32'd2);
        chk("ctrl_wr_err",      {31'b0, er}, 32'h0);
        chk("ctrl_during_resp", cr, 32'h0);
        chk("ctrl_after_resp",  mon_ctrl, 32'hDEAD_BEEF);

        for (int i = 0; i < 16; i++) begin
            xfer(v[i].wr, v[i].addr, v[i].data, rd, er, lat, cr);
            chk({v[i].name, "_lat"}, 32'(lat), 32'd2);
            chk({v[i].name, "_err"}, {31'b0, er}, {31'b0, v[i].exp_err});
            if (!v[i].wr || v[i].exp_err)
                chk({v[i].name, "_rdata"}, rd, v[i].exp_rdata);
        end
        chk("ctrl_after_table", mon_ctrl, 32'hDEAD_BEEF);

        // Zero wait states, back-to-back transfers
        cur = 0;
        do_reset();
        xfer(1'b1, 32'h8000_0004, 32'hAAAA_0001, rd, er, lat, cr);
        chk("ws0_wr1_lat", 32'(lat), 32'd1);
        xfer(1'b1, 32'h8000_0008, 32'hBBBB_0002, rd, er, lat, cr);
        chk("ws0_wr2_lat", 32'(lat), 32'd1);
        xfer(1'b0, 32'h8000_0004, 32'h0, rd, er, lat, cr);
        chk("ws0_rd1_lat", 32'(lat), 32'd1);
        chk("ws0_rd1", rd, 32'hAAAA_0001);
        xfer(1'b0, 32'h8000_0008, 32'h0, rd, er, lat, cr);
        chk("ws0_rd2", rd, 32'hBBBB_0002);

        // Three wait states, back-to-back transfers
        cur = 3;
        do_reset();
        xfer(1'b1, 32'h8000_0004, 32'hAAAA_0001, rd, er, lat, cr);
        chk("ws3_wr1_lat", 32'(lat), 32'd4);
        xfer(1'b1, 32'h8000_0008, 32'hBBBB_0002, rd, er, lat, cr);
        chk("ws3_wr2_lat", 32'(lat), 32'd4);
        xfer(1'b1, 32'h8000_0000, 32'h0000_00C0, rd, er, lat, cr);
        xfer(1'b0, 32'h8000_0004, 32'h0, rd, er, lat, cr);
        chk("ws3_rd1_lat", 32'(lat), 32'd4);
        chk("ws3_rd1", rd, 32'hAAAA_0001);
        xfer(1'b0, 32'h8000_0008, 32'h0, rd, er, lat, cr);
        chk("ws3_rd2", rd, 32'hBBBB_0002);

        // Drop select in the middle of the wait phase
        Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h8000_000C; Pwdata = 32'h3333_0000;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk); #1;
        Pselx = 3'b000; Penable = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge Hclk);
            if (mon_pready) seen = 1'b1;
        end
        @(posedge Hclk); #1;
        chk("abort_no_ready", {31'b0, seen}, 32'h0);
        xfer(1'b0, 32'h8000_000C, 32'h0, rd, er, lat, cr);
        chk("abort_next_lat", 32'(lat), 32'd4);
        chk("abort_r3_unchanged", rd, 32'h0);

        // Asynchronous reset while waiting
        chk("ctrl_pre_rst", mon_ctrl, 32'h0000_00C0);
        Pselx = 3'b001; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h8000_0004;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        @(posedge Hclk); #3;
        Hreset = 1'b0;
        #1;
        chk("arst_pready",  {31'b0, mon_pready},  32'h0);
        chk("arst_pslverr", {31'b0, mon_pslverr}, 32'h0);
        chk("arst_prdata",  mon_prdata, 32'h0);
        chk("arst_ctrl",    mon_ctrl,   32'h0);
        Pselx = 3'b000; Penable = 1'b0;
        Status_in = 32'h0000_00FF;
        @(posedge Hclk); #1;
        Hreset = 1'b1;
        xfer(1'b0, 32'h8000_0018, 32'h0, rd, er, lat, cr);
        chk("arst_status_lat", 32'(lat), 32'd4);
        chk("arst_status", rd, 32'h0000_00FF);
        xfer(1'b0, 32'h8000_0004, 32'h0, rd, er, lat, cr);
        chk("arst_r1_cleared", rd, 32'h0);
        xfer(1'b0, 32'h8000_0008, 32'h0, rd, er, lat, cr);
        chk("arst_r2_cleared", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
